// File: rtl/wb_regfile_commit.sv
// Writeback stage and architectural register file: selects the writeback value,
// commits it, and serves two bypassed read ports for ID.
module wb_regfile_commit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [2:0]        M_WB,
  input  logic [5:0]        WB_Opcode,
  input  logic [DATA_W-1:0] WB_ALU_RESULT,
  input  logic [DATA_W-1:0] WB_RD_Data,
  input  logic [4:0]        WB_RD,
  input  logic [DATA_W-1:0] WB_PC_4,
  input  logic [4:0]        RS_ADDR,
  input  logic [4:0]        RT_ADDR,
  output logic [DATA_W-1:0] RS_DATA,
  output logic [DATA_W-1:0] RT_DATA,
  output logic              WB_WE,
  output logic [4:0]        WB_WADDR,
  output logic [DATA_W-1:0] WB_WDATA,
  output logic              MISALIGN_ERR,
  output logic [CNT_W-1:0]  COMMIT_CNT
);
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic              reg_write, mem_to_reg, link;
  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  logic              mis_raw, misaligned;
  logic [DATA_W-1:0] regs [32];

  assign {reg_write, mem_to_reg, link} = M_WB;
  assign off = WB_ALU_RESULT[1:0];

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    ld_byte = WB_RD_Data[31:24];
    case (off)
      2'd1:    ld_byte = WB_RD_Data[23:16];
      2'd2:    ld_byte = WB_RD_Data[15:8];
      2'd3:    ld_byte = WB_RD_Data[7:0];
      default: ld_byte = WB_RD_Data[31:24];
    endcase
    ld_half = off[1] ? WB_RD_Data[15:0] : WB_RD_Data[31:16];
    ld_data = WB_RD_Data;
    mis_raw = 1'b0;
    case (WB_Opcode)
      OP_LB:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      OP_LBU: ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      OP_LH:  begin ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half}; mis_raw = off[0]; end
      OP_LHU: begin ld_data = {{(DATA_W-16){1'b0}}, ld_half}; mis_raw = off[0]; end
      OP_LW:  mis_raw = (off != 2'd0);
      default: ld_data = WB_RD_Data;
    endcase
    misaligned = mem_to_reg & mis_raw;
  end

  assign WB_WDATA = link ? WB_PC_4 : (mem_to_reg ? ld_data : WB_ALU_RESULT);
  assign WB_WE    = RESET & reg_write & (WB_RD != 5'd0) & ~misaligned;
  assign WB_WADDR = WB_RD;

  // regs[0] is never written (WB_WE excludes $0), so it stays zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      COMMIT_CNT   <= '0;
      MISALIGN_ERR <= 1'b0;
    end else begin
      if (WB_WE) begin
        regs[WB_RD] <= WB_WDATA;
        COMMIT_CNT  <= COMMIT_CNT + 1'b1;
      end
      if (reg_write & misaligned) MISALIGN_ERR <= 1'b1;
    end
  end

  logic [1:0][4:0]        raddr;
  logic [1:0][DATA_W-1:0] rdata;
  assign raddr = {RT_ADDR, RS_ADDR};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rdata[p] = (raddr[p] == 5'd0)               ? '0 :
                      (WB_WE && raddr[p] == WB_WADDR)  ? WB_WDATA :
                                                         regs[raddr[p]];
  end

  assign RS_DATA = rdata[0];
  assign RT_DATA = rdata[1];
endmodule

// File: tb/tb_wb_regfile_commit.sv
// Directed plus randomized check of wb_regfile_commit against a behavioural
// register-file model; a CNT_W=4 twin exercises counter wrap.
module tb_wb_regfile_commit;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  M_WB;
  logic [5:0]  WB_Opcode;
  logic [31:0] WB_ALU_RESULT, WB_RD_Data, WB_PC_4;
  logic [4:0]  WB_RD, RS_ADDR, RT_ADDR;
  logic [31:0] RS_DATA, RT_DATA, WB_WDATA, COMMIT_CNT;
  logic        WB_WE, MISALIGN_ERR;
  logic [4:0]  WB_WADDR;
  logic [31:0] rs4, rt4, wdata4;
  logic        we4, mis4;
  logic [4:0]  waddr4;
  logic [3:0]  cnt4;

  wb_regfile_commit #(.DATA_W(32), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .M_WB(M_WB), .WB_Opcode(WB_Opcode),
    .WB_ALU_RESULT(WB_ALU_RESULT), .WB_RD_Data(WB_RD_Data), .WB_RD(WB_RD),
    .WB_PC_4(WB_PC_4), .RS_ADDR(RS_ADDR), .RT_ADDR(RT_ADDR),
    .RS_DATA(RS_DATA), .RT_DATA(RT_DATA), .WB_WE(WB_WE), .WB_WADDR(WB_WADDR),
    .WB_WDATA(WB_WDATA), .MISALIGN_ERR(MISALIGN_ERR), .COMMIT_CNT(COMMIT_CNT));

  wb_regfile_commit #(.DATA_W(32), .CNT_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .M_WB(M_WB), .WB_Opcode(WB_Opcode),
    .WB_ALU_RESULT(WB_ALU_RESULT), .WB_RD_Data(WB_RD_Data), .WB_RD(WB_RD),
    .WB_PC_4(WB_PC_4), .RS_ADDR(RS_ADDR), .RT_ADDR(RT_ADDR),
    .RS_DATA(rs4), .RT_DATA(rt4), .WB_WE(we4), .WB_WADDR(waddr4),
    .WB_WDATA(wdata4), .MISALIGN_ERR(mis4), .COMMIT_CNT(cnt4));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [32];
  logic [31:0] mcnt;
  logic        mflag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the load rules.
  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    int unsigned o = a[1:0];
    logic [7:0]  b = 8'(d >> (8 * (3 - o)));
    logic [15:0] h = 16'(d >> (16 * (1 - o / 2)));
    case (op)
      6'h20:   return 32'($signed(b));
      6'h24:   return {24'd0, b};
      6'h21:   return 32'($signed(h));
      6'h25:   return {16'd0, h};
      default: return d;
    endcase
  endfunction

  function automatic bit m_mis(input logic [5:0] op, input logic [31:0] a);
    return ((op == 6'h21 || op == 6'h25) && a[0]) || (op == 6'h23 && a[1:0] != 2'd0);
  endfunction

  function automatic bit m_we();
    return RESET && M_WB[2] && WB_RD != 0 && !(M_WB[1] && m_mis(WB_Opcode, WB_ALU_RESULT));
  endfunction

  function automatic logic [31:0] m_wdata();
    if (M_WB[0]) return WB_PC_4;
    if (M_WB[1]) return m_load(WB_Opcode, WB_ALU_RESULT, WB_RD_Data);
    return WB_ALU_RESULT;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (m_we() && a == WB_RD) return m_wdata();
    return mregs[a];
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".cnt"},  COMMIT_CNT, mcnt);
    chk({tag, ".cnt4"}, {28'd0, cnt4}, {28'd0, mcnt[3:0]});
    chk({tag, ".flag"}, {31'd0, MISALIGN_ERR}, {31'd0, mflag});
  endtask

  task automatic cyc(input string tag, input logic [2:0] m, input logic [5:0] op,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                     input logic [4:0] r, input logic [4:0] s, input logic [4:0] t);
    bit          we;
    logic [31:0] wd;
    M_WB = m; WB_Opcode = op; WB_ALU_RESULT = a; WB_RD_Data = d; WB_PC_4 = p;
    WB_RD = r; RS_ADDR = s; RT_ADDR = t;
    #1;
    we = m_we();
    wd = m_wdata();
    chk({tag, ".we"},    {31'd0, WB_WE}, {31'd0, we});
    chk({tag, ".waddr"}, {27'd0, WB_WADDR}, {27'd0, r});
    chk({tag, ".wdata"}, WB_WDATA, wd);
    chk({tag, ".rs"},    RS_DATA, m_read(s));
    chk({tag, ".rt"},    RT_DATA, m_read(t));
    @(posedge CLK);
    if (we) begin mregs[r] = wd; mcnt++; end
    if (m[2] && m[1] && m_mis(op, a)) mflag = 1'b1;
    #1;
    check_state(tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 0;
    mflag = 1'b0;
  endtask

  initial begin
    logic [2:0] mtab [5];
    logic [5:0] otab [6];
    logic [4:0] r;
    mtab[0] = 3'b000; mtab[1] = 3'b100; mtab[2] = 3'b110; mtab[3] = 3'b101; mtab[4] = 3'b100;
    otab[0] = 6'h20; otab[1] = 6'h21; otab[2] = 6'h23; otab[3] = 6'h24; otab[4] = 6'h25; otab[5] = 6'h0F;

    // Reset state
    RESET = 1'b0; M_WB = 3'b000; WB_Opcode = 6'h0; WB_ALU_RESULT = 0; WB_RD_Data = 0;
    WB_PC_4 = 0; WB_RD = 5'd5; RS_ADDR = 5'd5; RT_ADDR = 5'd0;
    model_reset();
    #2;
    chk("rst.rs", RS_DATA, 32'd0);
    chk("rst.we", {31'd0, WB_WE}, 32'd0);
    check_state("rst");
    @(posedge CLK); #1;
    RESET = 1'b1;

    for (int i = 0; i < 3; i++) cyc("bubble", 3'b000, 6'h23, 32'h2, 32'hDEAD_BEEF, 32'h4, 5'd5, 5'd5, 5'd6);

    // ALU write with same-cycle bypass, then readback from storage
    cyc("alu", 3'b100, 6'h0, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    cyc("rd5", 3'b000, 6'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);

    // Loads
    cyc("lb",  3'b110, 6'h20, 32'h1000_0001, 32'h1180_3344, 32'h0, 5'd6, 5'd6, 5'd5);
    cyc("lbu", 3'b110, 6'h24, 32'h1000_0001, 32'h1180_3344, 32'h0, 5'd7, 5'd6, 5'd7);
    cyc("lhu", 3'b110, 6'h25, 32'h1000_0002, 32'h1180_3344, 32'h0, 5'd8, 5'd7, 5'd8);
    cyc("lh",  3'b110, 6'h21, 32'h1000_0000, 32'h8180_3344, 32'h0, 5'd9, 5'd8, 5'd9);
    chk("lb.val", mregs[6], 32'hFFFF_FF80);
    chk("lhu.val", mregs[8], 32'h0000_3344);

    // Misaligned LW: dropped, flag sticky
    cyc("lw.mis", 3'b110, 6'h23, 32'h1000_0002, 32'hCAFE_F00D, 32'h0, 5'd10, 5'd10, 5'd10);
    cyc("post.mis", 3'b000, 6'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd6);

    // Link and $0
    cyc("link", 3'b101, 6'h03, 32'h0, 32'h0, 32'h0040_0010, 5'd31, 5'd31, 5'd31);
    cyc("r0",   3'b100, 6'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd31);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = 5'($urandom_range(0, 31));
      cyc("rnd", mtab[$urandom_range(0, 4)], otab[$urandom_range(0, 5)], $urandom, $urandom, $urandom,
          r, ($urandom_range(0, 1) != 0) ? r : 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Drive the narrow counter up to all-ones, then wrap
    for (int i = 0; i < 16 && mcnt[3:0] != 4'hF; i++)
      cyc("fill", 3'b100, 6'h0, $urandom, 32'h0, 32'h0, 5'd3, 5'd3, 5'd4);
    chk("cnt4.max", {28'd0, cnt4}, 32'h0000_000F);
    cyc("wrap", 3'b100, 6'h0, 32'h5A5A_5A5A, 32'h0, 32'h0, 5'd4, 5'd4, 5'd3);
    chk("cnt4.wrap", {28'd0, cnt4}, 32'h0);

    // Asynchronous reset in the middle of a write cycle
    M_WB = 3'b100; WB_RD = 5'd5; WB_ALU_RESULT = 32'h7777_7777; RS_ADDR = 5'd5; RT_ADDR = 5'd31;
    #1;
    chk("mid.we_pre", {31'd0, WB_WE}, 32'd1);
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    chk("mid.we", {31'd0, WB_WE}, 32'd0);
    chk("mid.rs", RS_DATA, 32'd0);
    chk("mid.rt", RT_DATA, 32'd0);
    check_state("mid");
    @(posedge CLK); #1;
    M_WB = 3'b000;
    RESET = 1'b1;
    for (int i = 0; i < 32; i++) begin
      RS_ADDR = 5'(i); RT_ADDR = 5'(31 - i);
      #1;
      chk("clr.rs", RS_DATA, 32'd0);
      chk("clr.rt", RT_DATA, 32'd0);
    end
    check_state("clr");
    cyc("after", 3'b100, 6'h0, 32'hABCD_0123, 32'h0, 32'h0, 5'd12, 5'd12, 5'd12);
    cyc("after.rd", 3'b000, 6'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
